// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: owns the 32-entry register file, tracks pending destinations
// in a scoreboard, stalls on RAW/WAW hazards and hands registered operands to execute.
module operand_fetch_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int ERRW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [3:0]      aluop,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] imm,
   input  logic            hata,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_opcode,
   output logic [3:0]      out_aluop,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_op_a,
   output logic [XLEN-1:0] out_op_b,
   output logic [XLEN-1:0] out_imm,
   output logic [ERRW-1:0] err_count
);

   localparam logic [6:0]      OP_R    = 7'b0000001;
   localparam logic [6:0]      OP_I    = 7'b0000011;
   localparam logic [6:0]      OP_U    = 7'b0000111;
   localparam logic [6:0]      OP_B    = 7'b0001111;
   localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

   logic [XLEN-1:0] rf_q [NREG];
   logic [NREG-1:0] pending_q, pending_d;
   logic            out_valid_q;
   logic [6:0]      out_opcode_q;
   logic [3:0]      out_aluop_q;
   logic [4:0]      out_rd_q;
   logic [XLEN-1:0] out_op_a_q, out_op_b_q, out_imm_q;
   logic [ERRW-1:0] err_q;

   logic uses_rs1, uses_rs2, writes_rd, known_op;
   logic is_err, wb_hit, eff_wr, rs1_busy, rs2_busy, waw, hazard, issue;
   logic [XLEN-1:0] op_a_d, op_b_d;

   // A used source reads zero for x0, the writeback value when it targets the same
   // register this cycle, otherwise the register file.
   function automatic logic [XLEN-1:0] pick_operand(input logic            used,
                                                    input logic [4:0]      idx,
                                                    input logic [XLEN-1:0] rf_val,
                                                    input logic            bypass_en,
                                                    input logic [4:0]      bypass_rd,
                                                    input logic [XLEN-1:0] bypass_val);
      if (!used || idx == 5'd0)
         return '0;
      if (bypass_en && bypass_rd == idx)
         return bypass_val;
      return rf_val;
   endfunction

   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      known_op  = 1'b1;
      case (opcode)
         OP_R:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
         OP_I:    begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
         OP_U:    writes_rd = 1'b1;
         OP_B:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         default: known_op = 1'b0;
      endcase
   end

   assign is_err   = in_valid && (hata || !known_op);
   assign wb_hit   = wb_en && (wb_rd != 5'd0);
   assign eff_wr   = writes_rd && (rd != 5'd0);
   assign rs1_busy = uses_rs1 && (rs1 != 5'd0) && pending_q[rs1] && !(wb_hit && wb_rd == rs1);
   assign rs2_busy = uses_rs2 && (rs2 != 5'd0) && pending_q[rs2] && !(wb_hit && wb_rd == rs2);
   assign waw      = eff_wr && pending_q[rd] && !(wb_hit && wb_rd == rd);
   assign hazard   = rs1_busy || rs2_busy || waw;
   // Error instructions are always swallowed, regardless of hazards or backpressure.
   assign in_ready = is_err || (!hazard && (!out_valid_q || out_ready));
   assign issue    = in_valid && in_ready && !is_err;

   assign op_a_d = pick_operand(uses_rs1, rs1, rf_q[rs1], wb_en, wb_rd, wb_data);
   assign op_b_d = pick_operand(uses_rs2, rs2, rf_q[rs2], wb_en, wb_rd, wb_data);

   // Writeback clears first so a same-cycle issue to the same register keeps it pending.
   always_comb begin
      pending_d = pending_q;
      if (wb_hit)
         pending_d[wb_rd] = 1'b0;
      if (issue && eff_wr)
         pending_d[rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= '0;
         pending_q    <= '0;
         out_valid_q  <= 1'b0;
         out_opcode_q <= '0;
         out_aluop_q  <= '0;
         out_rd_q     <= '0;
         out_op_a_q   <= '0;
         out_op_b_q   <= '0;
         out_imm_q    <= '0;
         err_q        <= '0;
      end else begin
         if (wb_hit)
            rf_q[wb_rd] <= wb_data;
         pending_q <= pending_d;
         if (issue) begin
            out_valid_q  <= 1'b1;
            out_opcode_q <= opcode;
            out_aluop_q  <= aluop;
            out_rd_q     <= eff_wr ? rd : 5'd0;
            out_op_a_q   <= op_a_d;
            out_op_b_q   <= op_b_d;
            out_imm_q    <= imm;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (is_err && err_q != '1)
            err_q <= err_q + ERR_ONE;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_opcode = out_opcode_q;
   assign out_aluop  = out_aluop_q;
   assign out_rd     = out_rd_q;
   assign out_op_a   = out_op_a_q;
   assign out_op_b   = out_op_b_q;
   assign out_imm    = out_imm_q;
   assign err_count  = err_q;

endmodule
